// File: rtl/ycr_reset_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ycr_reset_seq_ctrl
// Reset sequencer for the system and core reset domains. A full request
// (software, watchdog or debug-system) or rst_n_mux holds both domains in
// reset. Once the request is gone the system domain is released, the
// downstream buffer acknowledge is awaited (with timeout), and then the
// core domain is released after a fixed delay. A debug core-only request
// recycles the core domain alone.
//
// Optional feature macro: YCR_RST_CAUSE_EN (sticky reset-cause register).
//
// Ports:
//   clk               sequencer clock
//   rst_n_mux         async active-low reset (already test-muxed)
//   test_mode         scan mode select
//   test_rst_n        scan reset, drives the release outputs in scan mode
//   soft_rst_req      software full-reset request (level)
//   wdt_rst_req       watchdog full-reset request (level)
//   dbg_sys_rst_req   debug full-reset request (level)
//   dbg_core_rst_req  debug core-only reset request (level)
//   sys_rst_status    downstream system reset buffer status (1 = released)
//   sys_rst_n_req     system reset request to downstream sync/buffer cell
//   core_rst_n_req    core reset request to downstream sync/buffer cell
//   rst_done          sequence complete, both domains released
//   ack_tmo_err       sticky system-ack timeout flag
//   cause_clr         single-cycle clear of rst_cause
//   rst_cause         sticky cause {dbg, wdt, soft, por}
//
// States:
//   HOLD      | both domains held, counting the hold time
//   REL_SYS   | releasing the system domain
//   WAIT_ACK  | waiting for the system buffer acknowledge (or timeout)
//   CORE_DLY  | counting the delay before core release
//   RUN       | both domains released
//   CORE_HOLD | core-only reset hold, system domain stays released
// ---------------------------------------------------------------------------
module ycr_reset_seq_ctrl #(
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned CORE_DLY    = 4,
  parameter int unsigned ACK_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n_mux,
  input  logic       test_mode,
  input  logic       test_rst_n,
  input  logic       soft_rst_req,
  input  logic       wdt_rst_req,
  input  logic       dbg_sys_rst_req,
  input  logic       dbg_core_rst_req,
  input  logic       sys_rst_status,
  output logic       sys_rst_n_req,
  output logic       core_rst_n_req,
  output logic       rst_done,
  output logic       ack_tmo_err,
  input  logic       cause_clr,
  output logic [3:0] rst_cause
);

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] DLY_LAST  = 8'(CORE_DLY - 1);
  localparam logic [7:0] ACK_LAST  = 8'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_REL_SYS   = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_CORE_DLY  = 3'd3,
    ST_RUN       = 3'd4,
    ST_CORE_HOLD = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       sys_q;
  logic       core_q;
  logic       done_q;
  logic       tmo_q;
  logic       full_req;

  assign full_req = soft_rst_req | wdt_rst_req | dbg_sys_rst_req;

  always_ff @(posedge clk or negedge rst_n_mux) begin
    if (!rst_n_mux) begin
      state  <= ST_HOLD;
      cnt    <= '0;
      sys_q  <= 1'b0;
      core_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else if (full_req) begin
      // A full request overrides every state and also clears the timeout flag.
      state  <= ST_HOLD;
      cnt    <= '0;
      sys_q  <= 1'b0;
      core_q <= 1'b0;
      done_q <= 1'b0;
      tmo_q  <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (cnt == HOLD_LAST) state <= ST_REL_SYS;
          else                  cnt   <= cnt + 8'd1;
        end
        ST_REL_SYS: begin
          sys_q <= 1'b1;
          cnt   <= '0;
          state <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          // Acknowledge takes priority over a coincident timeout.
          if (sys_rst_status) begin
            state <= ST_CORE_DLY;
            cnt   <= '0;
          end else if (cnt == ACK_LAST) begin
            tmo_q <= 1'b1;
            state <= ST_CORE_DLY;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_CORE_DLY: begin
          if (cnt == DLY_LAST) begin
            core_q <= 1'b1;
            done_q <= 1'b1;
            state  <= ST_RUN;
            cnt    <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        ST_RUN: begin
          if (dbg_core_rst_req) begin
            core_q <= 1'b0;
            done_q <= 1'b0;
            cnt    <= '0;
            state  <= ST_CORE_HOLD;
          end else begin
            done_q <= 1'b1;
          end
        end
        ST_CORE_HOLD: begin
          if (dbg_core_rst_req) begin
            cnt <= '0;
          end else if (cnt == HOLD_LAST) begin
            cnt   <= '0;
            state <= ST_CORE_DLY;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state <= ST_HOLD;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Scan mode bypasses the sequencer on the release outputs only.
  assign sys_rst_n_req  = test_mode ? test_rst_n : sys_q;
  assign core_rst_n_req = test_mode ? test_rst_n : core_q;
  assign rst_done       = test_mode ? test_rst_n : done_q;
  assign ack_tmo_err    = tmo_q;

`ifdef YCR_RST_CAUSE_EN
  logic [3:0] cause_q;
  logic [3:0] cause_set;

  // Bit 0 (power-on) is only ever set by rst_n_mux itself.
  assign cause_set = {dbg_sys_rst_req | dbg_core_rst_req, wdt_rst_req, soft_rst_req, 1'b0};

  always_ff @(posedge clk or negedge rst_n_mux) begin
    if (!rst_n_mux)     cause_q <= 4'b0001;
    else if (cause_clr) cause_q <= cause_set;
    else                cause_q <= cause_q | cause_set;
  end

  assign rst_cause = cause_q;
`else
  logic unused_cause_clr;
  assign unused_cause_clr = cause_clr;
  assign rst_cause        = 4'b0000;
`endif

endmodule

// File: tb/tb_ycr_reset_seq_ctrl.sv
// ---------------------------------------------------------------------------
// Bench for ycr_reset_seq_ctrl. The reference model tracks release times as
// cycle timestamps (when the last full request was seen, when the ack came,
// when the core is due) rather than as an explicit state machine.
// ---------------------------------------------------------------------------
module tb_ycr_reset_seq_ctrl;

  localparam int HOLD = 16;
  localparam int DLY  = 4;
  localparam int TMO  = 64;

`ifdef YCR_RST_CAUSE_EN
  localparam bit CAUSE_EN = 1'b1;
`else
  localparam bit CAUSE_EN = 1'b0;
`endif
  localparam logic [3:0] CAUSE_RST = CAUSE_EN ? 4'b0001 : 4'b0000;

  logic       clk = 1'b0;
  logic       rst_n_mux = 1'b0;
  logic       test_mode = 1'b0;
  logic       test_rst_n = 1'b1;
  logic       soft_rst_req = 1'b0;
  logic       wdt_rst_req = 1'b0;
  logic       dbg_sys_rst_req = 1'b0;
  logic       dbg_core_rst_req = 1'b0;
  logic       sys_rst_status = 1'b0;
  logic       sys_rst_n_req;
  logic       core_rst_n_req;
  logic       rst_done;
  logic       ack_tmo_err;
  logic       cause_clr = 1'b0;
  logic [3:0] rst_cause;

  ycr_reset_seq_ctrl #(
    .HOLD_CYCLES(HOLD),
    .CORE_DLY   (DLY),
    .ACK_TIMEOUT(TMO)
  ) dut (
    .clk             (clk),
    .rst_n_mux       (rst_n_mux),
    .test_mode       (test_mode),
    .test_rst_n      (test_rst_n),
    .soft_rst_req    (soft_rst_req),
    .wdt_rst_req     (wdt_rst_req),
    .dbg_sys_rst_req (dbg_sys_rst_req),
    .dbg_core_rst_req(dbg_core_rst_req),
    .sys_rst_status  (sys_rst_status),
    .sys_rst_n_req   (sys_rst_n_req),
    .core_rst_n_req  (core_rst_n_req),
    .rst_done        (rst_done),
    .ack_tmo_err     (ack_tmo_err),
    .cause_clr       (cause_clr),
    .rst_cause       (rst_cause)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- timestamp reference model ----------------
  int         n       = 0;         // clock edges since reset release
  int         sys_at  = HOLD + 1;  // edge at which sys_rst_n_req rises
  int         ack_at  = -1;        // edge at which ack (or timeout) is taken
  int         core_at = -1;        // edge at which core_rst_n_req rises
  int         last_dbg = 0;
  bit         chold   = 1'b0;
  logic       m_tmo   = 1'b0;
  logic [3:0] m_cause = CAUSE_RST;

  initial forever begin
    @(posedge clk or negedge rst_n_mux);
    if (!rst_n_mux) begin
      n = 0; sys_at = HOLD + 1; ack_at = -1; core_at = -1;
      chold = 1'b0; m_tmo = 1'b0; m_cause = CAUSE_RST;
    end else begin
      logic [3:0] cset;
      n = n + 1;
      cset = {dbg_sys_rst_req | dbg_core_rst_req, wdt_rst_req, soft_rst_req, 1'b0};
      if (CAUSE_EN) m_cause = cause_clr ? cset : (m_cause | cset);
      if (soft_rst_req | wdt_rst_req | dbg_sys_rst_req) begin
        sys_at = n + HOLD + 1; ack_at = -1; core_at = -1; chold = 1'b0; m_tmo = 1'b0;
      end else if (ack_at < 0) begin
        if (n > sys_at) begin
          if (sys_rst_status) begin
            ack_at = n; core_at = n + DLY;
          end else if (n == sys_at + TMO) begin
            ack_at = n; core_at = n + DLY; m_tmo = 1'b1;
          end
        end
      end else if (dbg_core_rst_req &&
                   (n > core_at || (chold && n <= last_dbg + HOLD))) begin
        last_dbg = n; chold = 1'b1; core_at = n + HOLD + DLY;
      end
    end
  end

  // ---------------- per-cycle compare + edge trackers ----------------
  int sys_rise = -1, sys_fall = -1, core_rise = -1, core_fall = -1;
  int done_rise = -1, tmo_rise = -1;
  logic p_sys = 0, p_core = 0, p_done = 0, p_tmo = 0;

  initial forever begin
    logic e_sys, e_core, e_done;
    @(negedge clk);
    e_sys  = (n >= sys_at);
    e_core = (core_at >= 0) && (n >= core_at);
    e_done = e_core;
    if (test_mode) begin
      e_sys = test_rst_n; e_core = test_rst_n; e_done = test_rst_n;
    end
    chk("sys_rst_n_req", int'(sys_rst_n_req), int'(e_sys));
    chk("core_rst_n_req", int'(core_rst_n_req), int'(e_core));
    chk("rst_done", int'(rst_done), int'(e_done));
    chk("ack_tmo_err", int'(ack_tmo_err), int'(m_tmo));
    chk("rst_cause", int'(rst_cause), int'(m_cause));
    if (sys_rst_n_req && !p_sys)   sys_rise  = n;
    if (!sys_rst_n_req && p_sys)   sys_fall  = n;
    if (core_rst_n_req && !p_core) core_rise = n;
    if (!core_rst_n_req && p_core) core_fall = n;
    if (rst_done && !p_done)       done_rise = n;
    if (ack_tmo_err && !p_tmo)     tmo_rise  = n;
    p_sys = sys_rst_n_req; p_core = core_rst_n_req; p_done = rst_done; p_tmo = ack_tmo_err;
  end

  // Advance to the negedge following edge 'target', then step off the edge.
  task automatic wait_n(input int target);
    int guard = 0;
    while (n < target && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (n < target) begin
      n_fail++;
      $display("FAIL wait_n: reached edge %0d, required %0d", n, target);
    end
    #2;
  endtask

  function automatic logic step_req(input logic cur, input int inv);
    if (cur) return ($urandom_range(0, 3) != 0);
    return ($urandom_range(0, inv - 1) == 0);
  endfunction

  initial begin
    // Power-on: status follows two edges behind sys release.
    repeat (3) @(negedge clk);
    #1;
    chk("por_sys_in_reset", int'(sys_rst_n_req), 0);
    chk("por_cause_in_reset", int'(rst_cause), int'(CAUSE_RST));
    #1 rst_n_mux = 1'b1;
    wait_n(18);
    sys_rst_status = 1'b1;
    wait_n(25);
    chk("por_sys_rise", sys_rise, 17);
    chk("por_core_rise", core_rise, 23);
    chk("por_done_rise", done_rise, 23);
    chk("por_cause", int'(rst_cause), CAUSE_EN ? 1 : 0);

    // Ack timeout after a fresh reset.
    sys_rst_status = 1'b0;
    rst_n_mux = 1'b0;
    @(negedge clk); #2;
    rst_n_mux = 1'b1;
    wait_n(90);
    chk("tmo_rise", tmo_rise, 81);
    chk("tmo_core_rise", core_rise, 85);
    chk("tmo_done_rise", done_rise, 85);
    chk("tmo_sys_rise", sys_rise, 17);
    sys_rst_status = 1'b1;

    // Watchdog held for 10 sampled edges (96..105).
    wait_n(95);
    wdt_rst_req = 1'b1;
    wait_n(105);
    wdt_rst_req = 1'b0;
    wait_n(129);
    chk("wdt_sys_fall", sys_fall, 96);
    chk("wdt_sys_rise", sys_rise, 122);
    chk("wdt_core_rise", core_rise, 127);
    chk("wdt_tmo_cleared", int'(ack_tmo_err), 0);
    chk("wdt_cause", int'(rst_cause), CAUSE_EN ? 4'b0101 : 0);

    // Debug core-only pulse at edge 131.
    wait_n(130);
    dbg_core_rst_req = 1'b1;
    wait_n(131);
    dbg_core_rst_req = 1'b0;
    wait_n(153);
    chk("dbgc_core_fall", core_fall, 131);
    chk("dbgc_core_rise", core_rise, 151);
    chk("dbgc_sys_stays", sys_fall, 96);

    // Soft and core-only request together: full reset wins.
    wait_n(155);
    soft_rst_req = 1'b1;
    dbg_core_rst_req = 1'b1;
    wait_n(156);
    soft_rst_req = 1'b0;
    dbg_core_rst_req = 1'b0;
    wait_n(179);
    chk("both_sys_fall", sys_fall, 156);
    chk("both_sys_rise", sys_rise, 173);
    chk("both_core_rise", core_rise, 178);
    chk("both_cause", int'(rst_cause), CAUSE_EN ? 4'b1111 : 0);
    wait_n(180);
    cause_clr = 1'b1;
    wait_n(181);
    cause_clr = 1'b0;
    chk("cause_cleared", int'(rst_cause), 0);

    // Scan mode: outputs follow test_rst_n while the FSM keeps going.
    wait_n(185);
    test_mode = 1'b1;
    test_rst_n = 1'b0;
    wdt_rst_req = 1'b1;
    #1;
    chk("tm_sys_lo", int'(sys_rst_n_req), 0);
    chk("tm_core_lo", int'(core_rst_n_req), 0);
    chk("tm_done_lo", int'(rst_done), 0);
    wait_n(186);
    wdt_rst_req = 1'b0;
    test_rst_n = 1'b1;
    #1;
    chk("tm_sys_hi", int'(sys_rst_n_req), 1);
    chk("tm_core_hi", int'(core_rst_n_req), 1);
    chk("tm_done_hi", int'(rst_done), 1);
    wait_n(190);
    test_mode = 1'b0;
    wait_n(210);
    chk("tm_sys_rise", sys_rise, 203);
    chk("tm_core_rise", core_rise, 208);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk); #2;
      if (!rst_n_mux) rst_n_mux = 1'b1;
      else if ($urandom_range(0, 999) == 0) rst_n_mux = 1'b0;
      soft_rst_req     = step_req(soft_rst_req, 300);
      wdt_rst_req      = step_req(wdt_rst_req, 300);
      dbg_sys_rst_req  = step_req(dbg_sys_rst_req, 400);
      dbg_core_rst_req = step_req(dbg_core_rst_req, 50);
      if ($urandom_range(0, 39) == 0) sys_rst_status = ~sys_rst_status;
      cause_clr = ($urandom_range(0, 49) == 0);
      if (test_mode) test_mode = ($urandom_range(0, 7) != 0);
      else           test_mode = ($urandom_range(0, 149) == 0);
      test_rst_n = 1'($urandom_range(0, 1));
    end
    test_mode = 1'b0;
    @(negedge clk);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
